// File: rtl/arb_mux.sv
// N-input registered multiplexer with valid/ready handshakes on every port.
// MODE selects fixed-priority (lowest index) or round-robin arbitration.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    // Handshakes: a beat moves on a port only in a cycle where its valid and
    // ready are both high; valid never waits on ready, and the output stage
    // accepts a new beat whenever it is empty or being drained this cycle.

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant;
    logic            any_valid;
    logic            load;
    int              idx;

    assign any_valid = |in_valid;
    // rst_n gates load so no channel sees a grant while reset is held.
    assign load      = rst_n && any_valid && (!out_valid || out_ready);

    always_comb begin
        grant = '0;
        idx   = 0;
        if (MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) grant = SELW'(i);
            end
        end else begin
            // Walk offsets from far to near so the channel closest to ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (in_valid[idx]) grant = SELW'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (load && (grant == SELW'(i))) in_ready[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_sel   <= grant;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if ((MODE == 1) && load) begin
            if (grant == SELW'(N - 1)) ptr <= '0;
            else                       ptr <= grant + SELW'(1);
        end
    end

endmodule
